bfd_regfile: RTL and testbench
==============================

Name: bfd_regfile

Overview:
- Register bank sitting directly downstream of the AXI4-Lite slave controller.
- Consumes reg_addr/reg_wdata/reg_wr/reg_rd and returns reg_rdata.
- Holds BFD session configuration, exposes session status, W1C interrupt status/mask and saturating packet counters.
- Drives a level interrupt to the CPU.

Parameters:
- VERSION, 32'h0001_0000, constant returned at 0x00.
- ADDR_W, 8, number of reg_addr LSBs decoded; upper bits ignored.
- TX_INTERVAL_RST, 32'd1_000_000, reset value of TX_INTERVAL (us).
- RX_INTERVAL_RST, 32'd1_000_000, reset value of RX_INTERVAL (us).
- DETECT_MULT_RST, 8'd3, reset value of CTRL[15:8].

Ports:
- s_axi_clk  in  1  sole clock.
- s_axi_rst  in  1  synchronous, active-high reset.
- reg_addr  in  32  byte address; bits [1:0] ignored.
- reg_wdata  in  32  write data; full-word writes only.
- reg_wr  in  1  one-cycle write strobe.
- reg_rd  in  1  one-cycle read strobe.
- reg_rdata  out  32  registered read data.
- sess_state  in  2  local session state (0 AdminDown, 1 Down, 2 Init, 3 Up).
- remote_state  in  2  remote session state.
- ev_up, ev_down, ev_rx_timeout  in  1 each  one-cycle event pulses.
- rx_pkt_ok, tx_pkt  in  1 each  one-cycle counter increment pulses.
- cfg_enable, cfg_loopback  out  1 each  CTRL[0], CTRL[1].
- cfg_detect_mult  out  8  CTRL[15:8].
- cfg_tx_interval, cfg_rx_interval, cfg_local_discr  out  32 each.
- irq  out  1  registered OR of (IRQ_STATUS & IRQ_MASK).

Behaviour:

Register map (word offsets; unmapped reads return 0, unmapped writes are ignored):
- 0x00 VERSION, RO.
- 0x04 CTRL, RW bits [15:8],[1:0]; other bits read 0.
- 0x08 TX_INTERVAL, RW.
- 0x0C RX_INTERVAL, RW.
- 0x10 LOCAL_DISCR, RW, reset 0.
- 0x14 STATUS, RO: [1:0] sess_state, [3:2] remote_state, sampled live at the read strobe.
- 0x18 IRQ_STATUS, W1C: [0] up, [1] down, [2] rx_timeout, [3] wr_collision.
- 0x1C IRQ_MASK, RW [3:0], reset 0.
- 0x20 RX_PKT_CNT, RO.
- 0x24 TX_PKT_CNT, RO.
- 0x28 CNT_CLR, WO: bit0 clears RX, bit1 clears TX; reads 0.
- 0x2C SCRATCH, RW, reset 0.

Reset values:
- reg_rdata=0, irq=0.
- All RW/W1C registers and counters reset to 0 except TX_INTERVAL, RX_INTERVAL and CTRL[15:8], which take their parameter values.

Write path:
- Register updates on the edge where reg_wr=1; cfg_* outputs reflect the new value the following cycle.

Read path:
- On reg_rd=1, reg_rdata loads the decoded value at the clock edge.
- It is held unchanged until the next reg_rd.
- Latency is one cycle, which matches the controller raising rvalid one cycle after reg_rd and holding it until rready.

Read/write collision:
- If reg_rd and reg_wr are high in the same cycle, reg_addr carries the read address.
- The read completes normally, the write is dropped, and IRQ_STATUS[3] sets.

IRQ_STATUS bits:
- Set by the corresponding event pulse.
- Cleared by writing 1 to the bit.
- Set and clear in the same cycle: set wins, bit stays 1.

irq:
- Registered, one cycle after the status/mask change.
- Stays high while any masked bit is 1.

Counters:
- 32-bit, +1 per pulse, saturate at 32'hFFFF_FFFF (no wrap).
- Clear and increment in the same cycle: result is 0 (clear wins).
- A read returns the pre-edge value.

Reset mid-operation:
- A reg_wr or reg_rd coinciding with s_axi_rst is ignored.
- All state takes reset values on that edge.

No state machine beyond the registers; all logic is one clocked process plus the decode.

Decomposition:
- Package bfd_regfile_pkg holds:
  - the address offset constants (ADDR_VERSION..ADDR_SCRATCH);
  - IRQ bit index constants;
  - the session-state encoding.
- One sub-module, bfd_sat_cnt (32-bit saturating counter with inc/clr, clr priority), instantiated twice.

Test Plan:
1. Reset, read 0x00, 0x08, 0x04 -> reg_rdata 32'h0001_0000, 32'd1_000_000, 32'h0000_0300 on the cycle after each reg_rd; held until the next reg_rd.
2. Write 0x04=32'hFFFF_FFFF, read back -> 32'h0000_FF03; cfg_enable=1, cfg_detect_mult=8'hFF one cycle after the write.
3. Pulse ev_down with IRQ_MASK=0 -> IRQ_STATUS=0x2, irq=0. Write IRQ_MASK=0x2 -> irq=1. Write 0x18=0x2 in the same cycle as an ev_down pulse -> status stays 0x2. A later write of 0x2 with no pulse -> status 0, irq=0 one cycle later.
4. Preload RX counter to 32'hFFFF_FFFE (5 pulses after forcing), apply 3 rx_pkt_ok pulses -> RX_PKT_CNT=32'hFFFF_FFFF. Write CNT_CLR=1 together with an rx_pkt_ok pulse -> 0.
5. Assert reg_rd(addr 0x2C) and reg_wr(wdata 0x1234) together -> SCRATCH unchanged, IRQ_STATUS[3]=1, read data valid.
6. Assert s_axi_rst for one cycle in the same cycle as reg_wr to 0x10 -> LOCAL_DISCR=0, reg_rdata=0, irq=0.

Source files
------------

// File: rtl/bfd_regfile_pkg.sv
// Shared register offsets, interrupt bit positions and session-state encoding for the BFD register bank.
// Pure declarations; no timing or flow-control behaviour lives here.
package bfd_regfile_pkg;

  localparam logic [7:0] ADDR_VERSION     = 8'h00;
  localparam logic [7:0] ADDR_CTRL        = 8'h04;
  localparam logic [7:0] ADDR_TX_INTERVAL = 8'h08;
  localparam logic [7:0] ADDR_RX_INTERVAL = 8'h0C;
  localparam logic [7:0] ADDR_LOCAL_DISCR = 8'h10;
  localparam logic [7:0] ADDR_STATUS      = 8'h14;
  localparam logic [7:0] ADDR_IRQ_STATUS  = 8'h18;
  localparam logic [7:0] ADDR_IRQ_MASK    = 8'h1C;
  localparam logic [7:0] ADDR_RX_PKT_CNT  = 8'h20;
  localparam logic [7:0] ADDR_TX_PKT_CNT  = 8'h24;
  localparam logic [7:0] ADDR_CNT_CLR     = 8'h28;
  localparam logic [7:0] ADDR_SCRATCH     = 8'h2C;

  localparam int IRQ_UP         = 0;
  localparam int IRQ_DOWN       = 1;
  localparam int IRQ_RX_TIMEOUT = 2;
  localparam int IRQ_WR_COLL    = 3;
  localparam int IRQ_W          = 4;

  localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    SESS_ADMIN_DOWN = 2'd0,
    SESS_DOWN       = 2'd1,
    SESS_INIT       = 2'd2,
    SESS_UP         = 2'd3
  } sess_state_e;

endpackage

// File: rtl/bfd_regfile_if.sv
// Register-access bus between the AXI4-Lite slave controller (master) and the register bank (slave).
// Strobes are single-cycle; read data returns registered one cycle after reg_rd with no backpressure.
interface bfd_regfile_if;
  import bfd_regfile_pkg::*;

  logic [31:0] reg_addr;
  logic [31:0] reg_wdata;
  logic        reg_wr;
  logic        reg_rd;
  logic [31:0] reg_rdata;

  modport master (
    output reg_addr, reg_wdata, reg_wr, reg_rd,
    input  reg_rdata
  );

  modport slave (
    input  reg_addr, reg_wdata, reg_wr, reg_rd,
    output reg_rdata
  );

endinterface

// File: rtl/bfd_regfile_sat_cnt.sv
// 32-bit saturating event counter; clear beats increment when both arrive together.
// New value visible one cycle after the pulse; never stalls its source.
module bfd_sat_cnt
  import bfd_regfile_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        inc_i,
  input  logic        clr_i,
  output logic [31:0] cnt_o
);

  logic [31:0] cnt_q;
  logic [31:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/bfd_regfile.sv
// BFD session register bank: configuration, live status, W1C interrupt status/mask and packet counters.
// Writes land on the strobe edge, read data is registered one cycle after reg_rd; the bank never stalls.
module bfd_regfile
  import bfd_regfile_pkg::*;
#(
  parameter logic [31:0] VERSION         = 32'h0001_0000,
  parameter int          ADDR_W          = 8,
  parameter logic [31:0] TX_INTERVAL_RST = 32'd1_000_000,
  parameter logic [31:0] RX_INTERVAL_RST = 32'd1_000_000,
  parameter logic [7:0]  DETECT_MULT_RST = 8'd3
) (
  input  logic            s_axi_clk,
  input  logic            s_axi_rst,
  bfd_regfile_if.slave    bus,
  input  logic [1:0]      sess_state,
  input  logic [1:0]      remote_state,
  input  logic            ev_up,
  input  logic            ev_down,
  input  logic            ev_rx_timeout,
  input  logic            rx_pkt_ok,
  input  logic            tx_pkt,
  output logic            cfg_enable,
  output logic            cfg_loopback,
  output logic [7:0]      cfg_detect_mult,
  output logic [31:0]     cfg_tx_interval,
  output logic [31:0]     cfg_rx_interval,
  output logic [31:0]     cfg_local_discr,
  output logic            irq
);

  logic              ctrl_en_q,  ctrl_en_d;
  logic              ctrl_lb_q,  ctrl_lb_d;
  logic [7:0]        det_mult_q, det_mult_d;
  logic [31:0]       tx_int_q,   tx_int_d;
  logic [31:0]       rx_int_q,   rx_int_d;
  logic [31:0]       discr_q,    discr_d;
  logic [IRQ_W-1:0]  irq_sts_q,  irq_sts_d;
  logic [IRQ_W-1:0]  irq_mask_q, irq_mask_d;
  logic [31:0]       scratch_q,  scratch_d;
  logic [31:0]       rdata_q,    rdata_d;
  logic              irq_q,      irq_d;

  logic [ADDR_W-1:0] off;
  logic              wr_en;
  logic              wr_coll;
  logic [IRQ_W-1:0]  irq_set;
  logic [IRQ_W-1:0]  irq_w1c;
  logic              rx_clr;
  logic              tx_clr;
  logic [31:0]       rx_cnt;
  logic [31:0]       tx_cnt;
  logic [31:0]       rd_val;
  logic              unused_addr;

  assign off         = {bus.reg_addr[ADDR_W-1:2], 2'b00};
  assign unused_addr = ^{bus.reg_addr[31:ADDR_W], bus.reg_addr[1:0]};

  // A simultaneous read owns reg_addr, so the write is dropped and flagged.
  assign wr_en   = bus.reg_wr & ~bus.reg_rd;
  assign wr_coll = bus.reg_wr &  bus.reg_rd;

  always_comb begin
    irq_set                 = '0;
    irq_set[IRQ_UP]         = ev_up;
    irq_set[IRQ_DOWN]       = ev_down;
    irq_set[IRQ_RX_TIMEOUT] = ev_rx_timeout;
    irq_set[IRQ_WR_COLL]    = wr_coll;
  end

  assign irq_w1c = (wr_en && (off == ADDR_W'(ADDR_IRQ_STATUS))) ? bus.reg_wdata[IRQ_W-1:0] : '0;
  assign rx_clr  = wr_en && (off == ADDR_W'(ADDR_CNT_CLR)) && bus.reg_wdata[0];
  assign tx_clr  = wr_en && (off == ADDR_W'(ADDR_CNT_CLR)) && bus.reg_wdata[1];

  bfd_sat_cnt u_rx_cnt (
    .clk_i (s_axi_clk),
    .rst_i (s_axi_rst),
    .inc_i (rx_pkt_ok),
    .clr_i (rx_clr),
    .cnt_o (rx_cnt)
  );

  bfd_sat_cnt u_tx_cnt (
    .clk_i (s_axi_clk),
    .rst_i (s_axi_rst),
    .inc_i (tx_pkt),
    .clr_i (tx_clr),
    .cnt_o (tx_cnt)
  );

  always_comb begin
    rd_val = '0;
    case (off)
      ADDR_W'(ADDR_VERSION):     rd_val = VERSION;
      ADDR_W'(ADDR_CTRL):        rd_val = {16'h0, det_mult_q, 6'h0, ctrl_lb_q, ctrl_en_q};
      ADDR_W'(ADDR_TX_INTERVAL): rd_val = tx_int_q;
      ADDR_W'(ADDR_RX_INTERVAL): rd_val = rx_int_q;
      ADDR_W'(ADDR_LOCAL_DISCR): rd_val = discr_q;
      ADDR_W'(ADDR_STATUS):      rd_val = {28'h0, remote_state, sess_state};
      ADDR_W'(ADDR_IRQ_STATUS):  rd_val = {{(32-IRQ_W){1'b0}}, irq_sts_q};
      ADDR_W'(ADDR_IRQ_MASK):    rd_val = {{(32-IRQ_W){1'b0}}, irq_mask_q};
      ADDR_W'(ADDR_RX_PKT_CNT):  rd_val = rx_cnt;
      ADDR_W'(ADDR_TX_PKT_CNT):  rd_val = tx_cnt;
      ADDR_W'(ADDR_SCRATCH):     rd_val = scratch_q;
      default:                   rd_val = '0;
    endcase
  end

  always_comb begin
    ctrl_en_d  = ctrl_en_q;
    ctrl_lb_d  = ctrl_lb_q;
    det_mult_d = det_mult_q;
    tx_int_d   = tx_int_q;
    rx_int_d   = rx_int_q;
    discr_d    = discr_q;
    irq_mask_d = irq_mask_q;
    scratch_d  = scratch_q;
    // Event set is applied after the clear so a coincident pulse keeps the bit.
    irq_sts_d  = (irq_sts_q & ~irq_w1c) | irq_set;
    rdata_d    = bus.reg_rd ? rd_val : rdata_q;
    irq_d      = |(irq_sts_q & irq_mask_q);
    if (wr_en) begin
      case (off)
        ADDR_W'(ADDR_CTRL): begin
          ctrl_en_d  = bus.reg_wdata[0];
          ctrl_lb_d  = bus.reg_wdata[1];
          det_mult_d = bus.reg_wdata[15:8];
        end
        ADDR_W'(ADDR_TX_INTERVAL): tx_int_d   = bus.reg_wdata;
        ADDR_W'(ADDR_RX_INTERVAL): rx_int_d   = bus.reg_wdata;
        ADDR_W'(ADDR_LOCAL_DISCR): discr_d    = bus.reg_wdata;
        ADDR_W'(ADDR_IRQ_MASK):    irq_mask_d = bus.reg_wdata[IRQ_W-1:0];
        ADDR_W'(ADDR_SCRATCH):     scratch_d  = bus.reg_wdata;
        default: ;
      endcase
    end
  end

  always_ff @(posedge s_axi_clk) begin
    if (s_axi_rst) begin
      ctrl_en_q  <= 1'b0;
      ctrl_lb_q  <= 1'b0;
      det_mult_q <= DETECT_MULT_RST;
      tx_int_q   <= TX_INTERVAL_RST;
      rx_int_q   <= RX_INTERVAL_RST;
      discr_q    <= '0;
      irq_sts_q  <= '0;
      irq_mask_q <= '0;
      scratch_q  <= '0;
      rdata_q    <= '0;
      irq_q      <= 1'b0;
    end else begin
      ctrl_en_q  <= ctrl_en_d;
      ctrl_lb_q  <= ctrl_lb_d;
      det_mult_q <= det_mult_d;
      tx_int_q   <= tx_int_d;
      rx_int_q   <= rx_int_d;
      discr_q    <= discr_d;
      irq_sts_q  <= irq_sts_d;
      irq_mask_q <= irq_mask_d;
      scratch_q  <= scratch_d;
      rdata_q    <= rdata_d;
      irq_q      <= irq_d;
    end
  end

  assign bus.reg_rdata   = rdata_q;
  assign irq             = irq_q;
  assign cfg_enable      = ctrl_en_q;
  assign cfg_loopback    = ctrl_lb_q;
  assign cfg_detect_mult = det_mult_q;
  assign cfg_tx_interval = tx_int_q;
  assign cfg_rx_interval = rx_int_q;
  assign cfg_local_discr = discr_q;

endmodule

// File: tb/tb_bfd_regfile.sv
// Randomised scoreboard bench for bfd_regfile: a register-level model predicts read data,
// interrupt and config outputs; a negedge monitor pops and compares independently of the stimulus.
module tb_bfd_regfile;
  import bfd_regfile_pkg::*;

  logic        clk;
  logic        rst;
  logic [1:0]  sess_state, remote_state;
  logic        ev_up, ev_down, ev_rx_timeout, rx_pkt_ok, tx_pkt;
  logic        cfg_enable, cfg_loopback, irq;
  logic [7:0]  cfg_detect_mult;
  logic [31:0] cfg_tx_interval, cfg_rx_interval, cfg_local_discr;

  bfd_regfile_if bus ();

  bfd_regfile dut (
    .s_axi_clk       (clk),
    .s_axi_rst       (rst),
    .bus             (bus),
    .sess_state      (sess_state),
    .remote_state    (remote_state),
    .ev_up           (ev_up),
    .ev_down         (ev_down),
    .ev_rx_timeout   (ev_rx_timeout),
    .rx_pkt_ok       (rx_pkt_ok),
    .tx_pkt          (tx_pkt),
    .cfg_enable      (cfg_enable),
    .cfg_loopback    (cfg_loopback),
    .cfg_detect_mult (cfg_detect_mult),
    .cfg_tx_interval (cfg_tx_interval),
    .cfg_rx_interval (cfg_rx_interval),
    .cfg_local_discr (cfg_local_discr),
    .irq             (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: architectural register contents after each clock edge.
  logic        m_en, m_lb, m_irq;
  logic [7:0]  m_mult;
  logic [31:0] m_tx, m_rx, m_discr, m_rxc, m_txc, m_scr;
  logic [3:0]  m_sts, m_mask;
  logic [31:0] exp_q[$];
  bit          started = 0;

  function automatic logic [31:0] model_read(input logic [7:0] off);
    case (off)
      8'h00:   return 32'h0001_0000;
      8'h04:   return {16'h0, m_mult, 6'h0, m_lb, m_en};
      8'h08:   return m_tx;
      8'h0C:   return m_rx;
      8'h10:   return m_discr;
      8'h14:   return {28'h0, remote_state, sess_state};
      8'h18:   return {28'h0, m_sts};
      8'h1C:   return {28'h0, m_mask};
      8'h20:   return m_rxc;
      8'h24:   return m_txc;
      8'h2C:   return m_scr;
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_edge();
    logic [7:0]  off;
    logic        rd, wr, coll, next_irq;
    logic [3:0]  w1c;
    logic [31:0] d;
    started = 1;
    if (rst) begin
      m_en = 0; m_lb = 0; m_mult = 8'd3; m_tx = 32'd1_000_000; m_rx = 32'd1_000_000;
      m_discr = 0; m_sts = 0; m_mask = 0; m_rxc = 0; m_txc = 0; m_scr = 0; m_irq = 0;
      return;
    end
    off  = {bus.reg_addr[7:2], 2'b00};
    d    = bus.reg_wdata;
    rd   = bus.reg_rd;
    wr   = bus.reg_wr && !bus.reg_rd;
    coll = bus.reg_wr && bus.reg_rd;
    if (rd) exp_q.push_back(model_read(off));
    next_irq = |(m_sts & m_mask);
    w1c   = (wr && off == 8'h18) ? d[3:0] : 4'h0;
    m_sts = (m_sts & ~w1c) | {coll, ev_rx_timeout, ev_down, ev_up};
    if (wr && off == 8'h28 && d[0]) m_rxc = 0;
    else if (rx_pkt_ok && m_rxc != 32'hFFFF_FFFF) m_rxc = m_rxc + 1;
    if (wr && off == 8'h28 && d[1]) m_txc = 0;
    else if (tx_pkt && m_txc != 32'hFFFF_FFFF) m_txc = m_txc + 1;
    if (wr) begin
      case (off)
        8'h04: begin m_en = d[0]; m_lb = d[1]; m_mult = d[15:8]; end
        8'h08: m_tx = d;
        8'h0C: m_rx = d;
        8'h10: m_discr = d;
        8'h1C: m_mask = d[3:0];
        8'h2C: m_scr = d;
        default: ;
      endcase
    end
    m_irq = next_irq;
  endtask

  // Monitor: compares every output half a cycle after each edge.
  logic        rd_seen, rst_seen;
  logic [31:0] last_rd;
  always @(posedge clk) begin
    rd_seen  <= bus.reg_rd && !rst;
    rst_seen <= rst;
  end

  always @(negedge clk) begin
    if (started) begin
      if (rst_seen) begin
        last_rd = 32'h0;
      end else if (rd_seen) begin
        if (exp_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL scoreboard: read seen with no expected entry at %0t", $time);
        end else begin
          last_rd = exp_q.pop_front();
        end
      end
      check("reg_rdata", bus.reg_rdata, last_rd);
      check("irq", {31'h0, irq}, {31'h0, m_irq});
      check("cfg_enable", {31'h0, cfg_enable}, {31'h0, m_en});
      check("cfg_loopback", {31'h0, cfg_loopback}, {31'h0, m_lb});
      check("cfg_detect_mult", {24'h0, cfg_detect_mult}, {24'h0, m_mult});
      check("cfg_tx_interval", cfg_tx_interval, m_tx);
      check("cfg_rx_interval", cfg_rx_interval, m_rx);
      check("cfg_local_discr", cfg_local_discr, m_discr);
    end
  end

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    rst = 0; bus.reg_rd = 0; bus.reg_wr = 0;
    ev_up = 0; ev_down = 0; ev_rx_timeout = 0; rx_pkt_ok = 0; tx_pkt = 0;
  endtask

  task automatic op(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
    bus.reg_rd = rd; bus.reg_wr = wr; bus.reg_addr = a; bus.reg_wdata = d;
    cyc();
  endtask

  logic [7:0] offs [14] = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h18,
                            8'h1C, 8'h20, 8'h24, 8'h28, 8'h2C, 8'h30, 8'hFC};

  initial begin
    logic [31:0] t;
    int r;
    rst = 1; bus.reg_rd = 0; bus.reg_wr = 0; bus.reg_addr = 0; bus.reg_wdata = 0;
    sess_state = 2'd3; remote_state = 2'd1;
    ev_up = 0; ev_down = 0; ev_rx_timeout = 0; rx_pkt_ok = 0; tx_pkt = 0;
    cyc();

    // Reset values and read hold.
    op(1, 0, 32'h00, 0); op(0, 0, 32'h08, 0); op(0, 0, 32'h04, 0);
    op(1, 0, 32'h08, 0); op(1, 0, 32'h04, 0); op(0, 0, 0, 0);
    op(1, 0, 32'h14, 0);

    // CTRL writable-bit masking.
    op(0, 1, 32'h04, 32'hFFFF_FFFF); op(1, 0, 32'h04, 0); op(0, 0, 0, 0);

    // Interrupt status, mask, W1C and set-beats-clear.
    ev_down = 1; op(0, 0, 0, 0);
    op(1, 0, 32'h18, 0); op(0, 0, 0, 0);
    op(0, 1, 32'h1C, 32'h2); op(0, 0, 0, 0); op(0, 0, 0, 0);
    ev_down = 1; op(0, 1, 32'h18, 32'h2); op(1, 0, 32'h18, 0);
    op(0, 1, 32'h18, 32'h2); op(1, 0, 32'h18, 0); op(0, 0, 0, 0); op(0, 0, 0, 0);

    // Counter saturation and clear-beats-increment.
    force dut.u_rx_cnt.cnt_q = 32'hFFFF_FFF9;
    #1;
    release dut.u_rx_cnt.cnt_q;
    m_rxc = 32'hFFFF_FFF9;
    for (int i = 0; i < 5; i++) begin rx_pkt_ok = 1; op(0, 0, 0, 0); end
    op(1, 0, 32'h20, 0);
    for (int i = 0; i < 3; i++) begin rx_pkt_ok = 1; op(0, 0, 0, 0); end
    op(1, 0, 32'h20, 0);
    rx_pkt_ok = 1; op(0, 1, 32'h28, 32'h1); op(1, 0, 32'h20, 0);
    tx_pkt = 1; op(0, 0, 0, 0); op(1, 0, 32'h24, 0);

    // Read/write collision.
    op(1, 1, 32'h2C, 32'h1234); op(1, 0, 32'h2C, 0); op(1, 0, 32'h18, 0);

    // Reset overriding a coincident write.
    op(0, 1, 32'h10, 32'hDEAD_BEEF); op(1, 0, 32'h10, 0);
    op(0, 1, 32'h1C, 32'hF); op(0, 0, 0, 0);
    rst = 1; op(0, 1, 32'h10, 32'h5555_AAAA); op(1, 0, 32'h10, 0); op(0, 0, 0, 0);

    // Randomised traffic.
    for (int n = 0; n < 2000; n++) begin
      r = $urandom_range(0, 99);
      t = $urandom;
      bus.reg_addr  = {t[31:8], offs[$urandom_range(0, 13)][7:2], t[1:0]};
      bus.reg_wdata = (r[0]) ? $urandom : {28'h0, 4'($urandom_range(0, 15))};
      bus.reg_rd    = (r < 35);
      bus.reg_wr    = (r >= 25 && r < 60);
      sess_state    = 2'($urandom_range(0, 3));
      remote_state  = 2'($urandom_range(0, 3));
      ev_up         = ($urandom_range(0, 15) == 0);
      ev_down       = ($urandom_range(0, 15) == 0);
      ev_rx_timeout = ($urandom_range(0, 15) == 0);
      rx_pkt_ok     = ($urandom_range(0, 3) == 0);
      tx_pkt        = ($urandom_range(0, 3) == 0);
      rst           = ($urandom_range(0, 255) == 0);
      cyc();
    end

    op(0, 0, 0, 0); op(0, 0, 0, 0);
    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
